load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-memory access stage of the RISC-V core, placed directly downstream of the ALU. It takes the ALU result as the effective address and the rs2 value as store data. It performs one byte, halfword or word load or store over a valid/ready memory bus, and returns the aligned, sign- or zero-extended load result to writeback. The core stalls between accepting an operation and seeing `result_valid`.

## Interface
- `s`, 32: data/address width; only 32 is supported (4 byte lanes).

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  core presents a memory operation
- `op_ready`  out  1  unit can accept; operation accepted when `op_valid && op_ready`
- `op_load`  in  1  1 = load, 0 = store
- `op_size`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `op_addr`  in  s  effective address (ALU output)
- `op_wdata`  in  s  store data (rs2 value)
- `result_valid`  out  1  one-cycle pulse: operation complete
- `result_data`  out  s  extended load data
- `misalign_err`  out  1  valid with `result_valid`; misaligned access
- `mem_req`  out  1  bus request
- `mem_ready`  in  1  bus accepts request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  s  word-aligned address (`[1:0]` = 0)
- `mem_wdata`  out  s  lane-shifted store data
- `mem_wstrb`  out  4  byte enables (0000 for loads)
- `mem_rvalid`  in  1  read data valid
- `mem_rdata`  in  s  read word

## Operation
- States: IDLE, REQ, WAIT, DONE. `op_ready` = (state == IDLE).
- IDLE, on accept: latch the operation and lane = `op_addr[1:0]`, precompute the strobe and shifted write data, then go to REQ.
- REQ: `mem_req`=1; `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` are held stable until `mem_ready`. On the handshake a store goes to DONE and a load goes to WAIT.
- WAIT: on `mem_rvalid`, capture the extracted data into `result_data` and go to DONE. `mem_rvalid` is ignored in every other state.
- DONE: `result_valid`=1 for exactly one cycle, then IDLE.
- Store strobes:
  - SB: `0001 << lane`, data = `op_wdata[7:0]` replicated on all lanes.
  - SH: `0011 << (lane & 2)`, data = `op_wdata[15:0]` replicated on both halves.
  - SW: `1111`, data = `op_wdata`.
- Load extraction:
  - LB/LBU: byte `lane`, sign-/zero-extended.
  - LH/LHU: half `lane[1]`, sign-/zero-extended.
  - LW: full word.
- Undefined `op_size` (011, 110, 111) is treated as W. Stores use `op_size[1:0]`, so 100 → SB and 101 → SH.
- `result_data` updates only on a completed load; it holds its value across stores and errors.
- `op_valid` while busy is not accepted; the core holds it.
- Reset mid-operation: return to IDLE immediately; `mem_req` drops asynchronously; a pending bus response is dropped.

## Timing
- Reset values:
  - `op_ready`=1
  - `result_valid`=0, `result_data`=0, `misalign_err`=0
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0
- All outputs are registered or decoded from state only; no input-to-output combinational path.
- Minimum store latency, with `mem_ready`=1: accept at cycle 0, `mem_req` at cycle 1, `result_valid` at cycle 2.
- Minimum load latency: accept at cycle 0, request at cycle 1, `mem_rvalid` at cycle 2, `result_valid` at cycle 3. `mem_rvalid` is expected no earlier than one cycle after the request handshake.
- Back-to-back operations: the next operation can be accepted in the cycle after DONE.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access (H with `addr[0]`=1, W with `addr[1:0]`≠0) is accepted, goes IDLE→DONE and issues no `mem_req`.
  - DONE asserts `misalign_err`=1 with `result_valid`; `result_data` is unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign_err` is tied to 0.
  - Offending low address bits are ignored: H uses the half selected by `addr[1]`; W uses lane 0.

## Test plan
- SW addr 0x104, data 0xDEADBEEF, `mem_ready`=1 → cycle 1: `mem_addr`=0x104, `mem_wstrb`=1111, `mem_we`=1; cycle 2: `result_valid`.
- SB addr 0x203, data 0x000000A5 → `mem_addr`=0x200, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5.
- LB addr 0x302, `mem_rdata`=0x12F0_3456 → `result_data`=0xFFFFFFF0; repeated as LBU → 0x000000F0; LHU addr 0x302 → 0x000012F0.
- LW with `mem_ready` low for 3 cycles and `mem_rvalid` 2 cycles later → request fields stable throughout; exactly one `result_valid`; `op_ready`=0 until DONE has passed.
- LH addr 0x101:
  - With `LSU_MISALIGN_TRAP_EN`: no `mem_req`; `result_valid` and `misalign_err` both 1 one cycle after accept.
  - Without: `mem_addr`=0x100 and lower half returned.
- `rst_n` low while in WAIT → `mem_req`=0, `op_ready`=1 immediately; a late `mem_rvalid` produces no `result_valid`.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store stage: one B/H/W access per operation over a valid/ready bus, with lane steering and load extension.
// Optional misalignment trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_load,
    input  logic [2:0]  op_size,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        result_valid,
    output logic [31:0] result_data,
    output logic        misalign_err,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        load_q, uns_q;
    logic [1:0]  size_q, lane_q;
    logic        we_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;

    logic        accept;
    logic        skip_bus;
    logic [3:0]  strb_d;
    logic [31:0] wdata_d;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_d;

    assign accept = op_valid && (state_q == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
    logic mis_d, mis_q;
    // Size codes 1x (W and the undefined ones) all need a word-aligned address.
    assign mis_d = (op_size[1:0] == 2'b01) ? op_addr[0]
                 : (op_size[1] ? |op_addr[1:0] : 1'b0);
    assign skip_bus     = mis_d;
    assign misalign_err = (state_q == S_DONE) && mis_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      mis_q <= 1'b0;
        else if (accept) mis_q <= mis_d;
    end
`else
    assign skip_bus     = 1'b0;
    assign misalign_err = 1'b0;
`endif

    // Store lane steering; low address bits below the access size are ignored.
    always_comb begin
        strb_d  = 4'b1111;
        wdata_d = op_wdata;
        case (op_size[1:0])
            2'b00: begin
                strb_d  = 4'b0001 << op_addr[1:0];
                wdata_d = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                strb_d  = 4'b0011 << {op_addr[1], 1'b0};
                wdata_d = {2{op_wdata[15:0]}};
            end
            default: ;
        endcase
        if (op_load) strb_d = 4'b0000;
    end

    always_comb begin
        byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   ext_d = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   ext_d = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: ext_d = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (op_valid)   state_d = skip_bus ? S_DONE : S_REQ;
            S_REQ:  if (mem_ready)  state_d = load_q ? S_WAIT : S_DONE;
            S_WAIT: if (mem_rvalid) state_d = S_DONE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            lane_q  <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= 4'b0000;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                load_q  <= op_load;
                uns_q   <= op_size[2];
                size_q  <= op_size[1:0];
                lane_q  <= op_addr[1:0];
                we_q    <= ~op_load;
                addr_q  <= {op_addr[31:2], 2'b00};
                wdata_q <= wdata_d;
                strb_q  <= strb_d;
            end
            if (state_q == S_WAIT && mem_rvalid) rdata_q <= ext_d;
        end
    end

    assign op_ready     = (state_q == S_IDLE);
    assign result_valid = (state_q == S_DONE);
    assign result_data  = rdata_q;
    assign mem_req      = (state_q == S_REQ);
    assign mem_we       = we_q;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_wstrb    = strb_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a reference model derived from the access rules.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_ready, op_load;
    logic [2:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        result_valid, misalign_err;
    logic [31:0] result_data;
    logic        mem_req, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int ncmp = 0;
    int nfail = 0;
    logic [31:0] exp_res = '0;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_load(op_load), .op_size(op_size), .op_addr(op_addr), .op_wdata(op_wdata),
        .result_valid(result_valid), .result_data(result_data), .misalign_err(misalign_err),
        .mem_req(mem_req), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full operation; rd = cycles mem_ready stays low, rv = cycles between handshake+1 and rvalid.
    task automatic do_op(input logic ld, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input int rd, input int rv, input logic [31:0] rdata);
        logic [1:0]  lane;
        logic        mis;
        logic [3:0]  estrb;
        logic [31:0] ewd, eres, piece;
        lane = addr[1:0];
        mis  = (sz[1:0] == 2'b01 && addr[0]) || (sz[1] && lane != 2'd0);
        if (sz[1:0] == 2'b00) begin
            estrb = 4'd1 << lane;
            ewd   = {24'd0, wd[7:0]} * 32'h01010101;
            piece = (rdata >> (8 * lane)) & 32'hFF;
            eres  = (!sz[2] && piece[7]) ? (piece | 32'hFFFFFF00) : piece;
        end else if (sz[1:0] == 2'b01) begin
            estrb = 4'd3 << (lane & 2'd2);
            ewd   = {16'd0, wd[15:0]} * 32'h00010001;
            piece = (rdata >> (16 * addr[1])) & 32'hFFFF;
            eres  = (!sz[2] && piece[15]) ? (piece | 32'hFFFF0000) : piece;
        end else begin
            estrb = 4'hF;
            ewd   = wd;
            eres  = rdata;
        end
        if (ld) estrb = 4'h0;

        @(negedge clk);
        chk("ready_idle", op_ready, 1);
        op_valid = 1; op_load = ld; op_size = sz; op_addr = addr; op_wdata = wd;
        @(negedge clk);
        // Junk presented while busy must be neither accepted nor leak into the latched op.
        op_load = $urandom_range(0, 1); op_size = 3'($urandom); op_addr = $urandom; op_wdata = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
        if (mis) begin
            op_valid = 0;
            chk("trap_noreq", mem_req, 0);
            chk("trap_rvalid", result_valid, 1);
            chk("trap_err", misalign_err, 1);
            chk("trap_rdata_hold", result_data, exp_res);
            @(negedge clk);
            chk("trap_rvalid_pulse", result_valid, 0);
            chk("trap_ready_back", op_ready, 1);
            return;
        end
`endif
        for (int k = 0; k <= rd; k++) begin
            chk("req_on", mem_req, 1);
            chk("req_busy", op_ready, 0);
            chk("req_norv", result_valid, 0);
            chk("req_addr", mem_addr, {addr[31:2], 2'b00});
            chk("req_we", mem_we, !ld);
            chk("req_strb", mem_wstrb, estrb);
            if (!ld) chk("req_wdata", mem_wdata, ewd);
            mem_ready = (k == rd);
            mem_rvalid = $urandom_range(0, 1);
            mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_ready = 0; mem_rvalid = 0;
        if (ld) begin
            for (int k = 0; k <= rv; k++) begin
                chk("wait_noreq", mem_req, 0);
                chk("wait_norv", result_valid, 0);
                chk("wait_busy", op_ready, 0);
                mem_rvalid = (k == rv);
                mem_rdata  = (k == rv) ? rdata : 32'($urandom);
                @(negedge clk);
            end
            mem_rvalid = 0;
            exp_res = eres;
        end
        op_valid = 0;
        chk("done_rvalid", result_valid, 1);
        chk("done_err", misalign_err, 0);
        chk("done_rdata", result_data, exp_res);
        chk("done_busy", op_ready, 0);
        chk("done_noreq", mem_req, 0);
        @(negedge clk);
        chk("after_rvalid", result_valid, 0);
        chk("after_ready", op_ready, 1);
    endtask

    initial begin
        rst_n = 0; op_valid = 0; op_load = 0; op_size = 0; op_addr = 0; op_wdata = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", op_ready, 1);
        chk("rst_rvalid", result_valid, 0);
        chk("rst_rdata", result_data, 0);
        chk("rst_err", misalign_err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_strb", mem_wstrb, 0);
        rst_n = 1;

        do_op(0, 3'b010, 32'h104, 32'hDEADBEEF, 0, 0, 0);
        do_op(0, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0);
        do_op(1, 3'b000, 32'h302, 0, 0, 0, 32'h12F03456);
        do_op(1, 3'b100, 32'h302, 0, 0, 0, 32'h12F03456);
        do_op(1, 3'b101, 32'h302, 0, 0, 0, 32'h12F03456);
        do_op(1, 3'b010, 32'h480, 0, 3, 2, 32'hCAFEF00D);
        do_op(1, 3'b001, 32'h101, 0, 0, 0, 32'hABCD8765);
        do_op(0, 3'b101, 32'h322, 32'h0000BEEF, 1, 0, 0);

        for (int i = 0; i < 60; i++)
            do_op($urandom_range(0, 1), 3'($urandom), $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

        // Reset while waiting for read data.
        @(negedge clk);
        op_valid = 1; op_load = 1; op_size = 3'b010; op_addr = 32'h40;
        @(negedge clk);
        op_valid = 0; mem_ready = 1;
        chk("rstw_req", mem_req, 1);
        @(negedge clk);
        mem_ready = 0;
        chk("rstw_inwait", op_ready, 0);
        rst_n = 0;
        #1;
        chk("rstw_req_low", mem_req, 0);
        chk("rstw_ready", op_ready, 1);
        chk("rstw_rdata", result_data, 0);
        exp_res = '0;
        @(negedge clk);
        rst_n = 1; mem_rvalid = 1; mem_rdata = 32'h5A5A1234;
        @(negedge clk);
        mem_rvalid = 0;
        chk("rstw_late_rv", result_valid, 0);
        chk("rstw_idle", op_ready, 1);
        chk("rstw_rdata_keep", result_data, 0);
        @(negedge clk);
        chk("rstw_late_rv2", result_valid, 0);

        // Reset while requesting: request must drop without a clock edge.
        op_valid = 1; op_load = 0; op_size = 3'b010; op_addr = 32'h80; op_wdata = 32'h1;
        @(negedge clk);
        op_valid = 0;
        chk("rstr_req", mem_req, 1);
        rst_n = 0;
        #1;
        chk("rstr_req_low", mem_req, 0);
        chk("rstr_ready", op_ready, 1);
        chk("rstr_strb", mem_wstrb, 0);
        @(negedge clk);
        rst_n = 1;
        do_op(1, 3'b001, 32'h0, 0, 0, 0, 32'h00008001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
